// File: rtl/klp32_pkg.sv
// Shared load/store mode encodings (RV32I funct3) and data-memory FSM states.
package klp32_pkg;

    localparam logic [2:0] LS_B  = 3'b000;
    localparam logic [2:0] LS_H  = 3'b001;
    localparam logic [2:0] LS_W  = 3'b010;
    localparam logic [2:0] LS_BU = 3'b100;
    localparam logic [2:0] LS_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } dmem_state_e;

endpackage

// File: rtl/dmem_align.sv
// Byte-lane steering for a 32-bit data memory: byte enables, store replication,
// load extraction/extension and alignment/mode fault detection.
module dmem_align
    import klp32_pkg::*;
(
    input  logic [1:0]  i_addr_lo,
    input  logic [2:0]  i_mode,
    input  logic        i_we,
    input  logic [31:0] i_wdata,
    input  logic [31:0] i_rword,
    output logic [3:0]  o_be,
    output logic [31:0] o_wdata_rep,
    output logic [31:0] o_load_data,
    output logic        o_fault
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic        misaligned;
    logic        bad_mode;

    always_comb begin
        byte_sel = 8'(i_rword >> {i_addr_lo, 3'b000});
        half_sel = i_addr_lo[1] ? i_rword[31:16] : i_rword[15:0];

        o_be        = '0;
        o_wdata_rep = i_wdata;
        misaligned  = 1'b0;
        bad_mode    = 1'b0;
        o_load_data = '0;

        // Stores look at the size bits only; the sign bit is meaningless for them.
        case (i_mode[1:0])
            2'b00: begin
                o_be        = 4'b0001 << i_addr_lo;
                o_wdata_rep = {4{i_wdata[7:0]}};
            end
            2'b01: begin
                o_be        = i_addr_lo[1] ? 4'b1100 : 4'b0011;
                o_wdata_rep = {2{i_wdata[15:0]}};
                misaligned  = i_addr_lo[0];
            end
            2'b10: begin
                o_be       = 4'b1111;
                misaligned = (i_addr_lo != 2'b00);
            end
            default: bad_mode = 1'b1;
        endcase

        if (!i_we) begin
            case (i_mode)
                LS_B:    o_load_data = {{24{byte_sel[7]}}, byte_sel};
                LS_BU:   o_load_data = {24'd0, byte_sel};
                LS_H:    o_load_data = {{16{half_sel[15]}}, half_sel};
                LS_HU:   o_load_data = {16'd0, half_sel};
                LS_W:    o_load_data = i_rword;
                default: bad_mode = 1'b1;
            endcase
        end

        o_fault = misaligned | bad_mode;
    end

endmodule

// File: rtl/dmem_responder.sv
// Word-organised data memory behind a valid/ready request/response handshake,
// with a fixed number of wait states between acceptance and response.
module dmem_responder
    import klp32_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned WAIT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_req_valid,
    output logic        o_req_ready,
    input  logic [31:0] i_req_addr,
    input  logic        i_req_we,
    input  logic [2:0]  i_req_mode,
    input  logic [31:0] i_req_wdata,
    output logic        o_rsp_valid,
    input  logic        i_rsp_ready,
    output logic [31:0] o_rsp_rdata,
    output logic        o_rsp_err
);

    localparam int unsigned AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [3:0] CNT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    dmem_state_e state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] addr_q, addr_d;
    logic        we_q, we_d;
    logic [2:0]  mode_q, mode_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;

    logic [31:0] mem [DEPTH_WORDS];

    logic [31:0] act_addr;
    logic        act_we;
    logic [2:0]  act_mode;
    logic [31:0] act_wdata;
    logic        in_range;
    logic [AW-1:0] idx;
    logic [31:0] rword;
    logic [3:0]  be;
    logic [31:0] wdata_rep;
    logic [31:0] load_data;
    logic        align_fault;
    logic        fault;
    logic        commit;
    logic        wr_en;

    // With zero wait states the commit edge is the accept edge, so the
    // datapath sees the live request in IDLE and the registered one afterwards.
    always_comb begin
        if (state_q == IDLE) begin
            act_addr  = i_req_addr;
            act_we    = i_req_we;
            act_mode  = i_req_mode;
            act_wdata = i_req_wdata;
        end else begin
            act_addr  = addr_q;
            act_we    = we_q;
            act_mode  = mode_q;
            act_wdata = wdata_q;
        end
        in_range = ({2'b00, act_addr[31:2]} < 32'(DEPTH_WORDS));
        idx      = act_addr[AW+1:2];
        rword    = in_range ? mem[idx] : '0;
        fault    = align_fault | ~in_range;
    end

    dmem_align u_align (
        .i_addr_lo   (act_addr[1:0]),
        .i_mode      (act_mode),
        .i_we        (act_we),
        .i_wdata     (act_wdata),
        .i_rword     (rword),
        .o_be        (be),
        .o_wdata_rep (wdata_rep),
        .o_load_data (load_data),
        .o_fault     (align_fault)
    );

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        addr_d      = addr_q;
        we_d        = we_q;
        mode_d      = mode_q;
        wdata_d     = wdata_q;
        rdata_d     = rdata_q;
        err_d       = err_q;
        commit      = 1'b0;
        o_req_ready = 1'b0;

        case (state_q)
            IDLE: begin
                o_req_ready = 1'b1;
                if (i_req_valid) begin
                    addr_d  = i_req_addr;
                    we_d    = i_req_we;
                    mode_d  = i_req_mode;
                    wdata_d = i_req_wdata;
                    cnt_d   = CNT_LOAD;
                    if (WAIT_CYCLES == 0) begin
                        state_d = RESP;
                        commit  = 1'b1;
                    end else begin
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = RESP;
                    commit  = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESP: begin
                if (i_rsp_ready) begin
                    state_d = IDLE;
                    rdata_d = '0;
                    err_d   = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase

        if (commit) begin
            err_d   = fault;
            rdata_d = (fault || act_we) ? '0 : load_data;
        end
        wr_en = commit && act_we && !fault;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            we_q    <= 1'b0;
            mode_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            we_q    <= we_d;
            mode_q  <= mode_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int unsigned b = 0; b < 4; b++) begin
                if (be[b]) mem[idx][8*b +: 8] <= wdata_rep[8*b +: 8];
            end
        end
    end

    assign o_rsp_valid = (state_q == RESP);
    assign o_rsp_rdata = rdata_q;
    assign o_rsp_err   = err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench: one responder with one wait state, one with none.
module tb_dmem_responder;
    import klp32_pkg::*;

    localparam int unsigned DEPTH = 64;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        req_valid, req_ready, req_we, rsp_valid, rsp_ready, rsp_err;
    logic [31:0] req_addr, req_wdata, rsp_rdata;
    logic [2:0]  req_mode;

    logic        z_valid, z_ready, z_we, z_rvalid, z_rready, z_err;
    logic [31:0] z_addr, z_wdata, z_rdata;
    logic [2:0]  z_mode;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    dmem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(1)) dut (
        .clk(clk), .reset(reset),
        .i_req_valid(req_valid), .o_req_ready(req_ready),
        .i_req_addr(req_addr), .i_req_we(req_we), .i_req_mode(req_mode),
        .i_req_wdata(req_wdata),
        .o_rsp_valid(rsp_valid), .i_rsp_ready(rsp_ready),
        .o_rsp_rdata(rsp_rdata), .o_rsp_err(rsp_err)
    );

    dmem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(0)) dut0 (
        .clk(clk), .reset(reset),
        .i_req_valid(z_valid), .o_req_ready(z_ready),
        .i_req_addr(z_addr), .i_req_we(z_we), .i_req_mode(z_mode),
        .i_req_wdata(z_wdata),
        .o_rsp_valid(z_rvalid), .i_rsp_ready(z_rready),
        .o_rsp_rdata(z_rdata), .o_rsp_err(z_err)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // One transaction on the WAIT_CYCLES=1 instance; hold = cycles of backpressure in RESP.
    task automatic xact(input string tag, input logic we, input logic [2:0] mode,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [31:0] exp_rdata, input logic exp_err, input int hold);
        int edges;
        logic [31:0] held;
        edges = 0;
        while (!req_ready && edges < 20) begin
            @(posedge clk); #1; edges++;
        end
        check({tag, " req_ready"}, 32'(req_ready), 32'd1);
        rsp_ready = (hold == 0);
        req_valid = 1'b1; req_we = we; req_mode = mode; req_addr = addr; req_wdata = wdata;
        @(posedge clk); #1;
        req_valid = 1'b0; req_addr = 'x; req_wdata = 'x; req_mode = 'x; req_we = 1'bx;
        edges = 0;
        while (!rsp_valid && edges < 20) begin
            @(posedge clk); #1; edges++;
        end
        check({tag, " latency"}, 32'(edges + 1), 32'd2);
        check({tag, " rdata"}, rsp_rdata, exp_rdata);
        check({tag, " err"}, 32'(rsp_err), 32'(exp_err));
        held = rsp_rdata;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            check({tag, " hold valid"}, 32'(rsp_valid), 32'd1);
            check({tag, " hold rdata"}, rsp_rdata, held);
            check({tag, " hold ready"}, 32'(req_ready), 32'd0);
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        check({tag, " done valid"}, 32'(rsp_valid), 32'd0);
        check({tag, " done err"}, 32'(rsp_err), 32'd0);
        check({tag, " done ready"}, 32'(req_ready), 32'd1);
    endtask

    initial begin
        reset = 1'b1;
        req_valid = 1'b0; req_we = 1'b0; req_mode = LS_W; req_addr = '0; req_wdata = '0;
        rsp_ready = 1'b1;
        z_valid = 1'b0; z_we = 1'b0; z_mode = LS_W; z_addr = '0; z_wdata = '0;
        z_rready = 1'b1;
        #12;
        check("reset valid", 32'(rsp_valid), 32'd0);
        check("reset rdata", rsp_rdata, 32'd0);
        check("reset err", 32'(rsp_err), 32'd0);
        reset = 1'b0;
        @(posedge clk); #1;
        check("post-reset ready", 32'(req_ready), 32'd1);

        xact("SW 0x10", 1'b1, LS_W, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0, 0);
        xact("LW 0x10", 1'b0, LS_W, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, 0);
        xact("SB 0x11", 1'b1, LS_B, 32'h11, 32'h0000007F, 32'h0, 1'b0, 0);
        xact("LB 0x11", 1'b0, LS_B, 32'h11, 32'h0, 32'h0000007F, 1'b0, 0);
        xact("LBU 0x13", 1'b0, LS_BU, 32'h13, 32'h0, 32'h000000DE, 1'b0, 0);
        xact("LH 0x12", 1'b0, LS_H, 32'h12, 32'h0, 32'hFFFFDEAD, 1'b0, 0);
        xact("LHU 0x12", 1'b0, LS_HU, 32'h12, 32'h0, 32'h0000DEAD, 1'b0, 0);
        xact("LB 0x10", 1'b0, LS_B, 32'h10, 32'h0, 32'hFFFFFFEF, 1'b0, 0);
        xact("LW 0x10 merged", 1'b0, LS_W, 32'h10, 32'h0, 32'hDEAD7FEF, 1'b0, 0);

        xact("SW 0x00", 1'b1, LS_W, 32'h00, 32'h01020304, 32'h0, 1'b0, 0);
        xact("LW 0x12 misal", 1'b0, LS_W, 32'h12, 32'h0, 32'h0, 1'b1, 0);
        xact("SH 0x01 misal", 1'b1, LS_H, 32'h01, 32'h0000FFFF, 32'h0, 1'b1, 0);
        xact("LW oob", 1'b0, LS_W, DEPTH * 4, 32'h0, 32'h0, 1'b1, 0);
        xact("SW oob", 1'b1, LS_W, DEPTH * 4, 32'hFFFFFFFF, 32'h0, 1'b1, 0);
        xact("L mode 011", 1'b0, 3'b011, 32'h10, 32'h0, 32'h0, 1'b1, 0);
        xact("L mode 110", 1'b0, 3'b110, 32'h10, 32'h0, 32'h0, 1'b1, 0);
        xact("LW 0x00 intact", 1'b0, LS_W, 32'h00, 32'h0, 32'h01020304, 1'b0, 0);
        xact("SH 0x02", 1'b1, LS_H, 32'h02, 32'hAAAA5566, 32'h0, 1'b0, 0);
        xact("LW 0x00 half", 1'b0, LS_W, 32'h00, 32'h0, 32'h55660304, 1'b0, 0);

        xact("LW 0x10 bp", 1'b0, LS_W, 32'h10, 32'h0, 32'hDEAD7FEF, 1'b0, 5);

        // Reset while a store waits must drop it.
        xact("SW 0x20", 1'b1, LS_W, 32'h20, 32'hCAFEF00D, 32'h0, 1'b0, 0);
        req_valid = 1'b1; req_we = 1'b1; req_mode = LS_W; req_addr = 32'h20;
        req_wdata = 32'h12345678;
        @(posedge clk); #1;
        req_valid = 1'b0;
        check("rst-wait pre valid", 32'(rsp_valid), 32'd0);
        check("rst-wait pre ready", 32'(req_ready), 32'd0);
        reset = 1'b1;
        #2;
        check("rst-wait valid", 32'(rsp_valid), 32'd0);
        check("rst-wait err", 32'(rsp_err), 32'd0);
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check("rst-wait after valid", 32'(rsp_valid), 32'd0);
            check("rst-wait after ready", 32'(req_ready), 32'd1);
        end
        xact("LW 0x20 prior", 1'b0, LS_W, 32'h20, 32'h0, 32'hCAFEF00D, 1'b0, 0);

        // Zero wait states: back-to-back with valid held high.
        z_valid = 1'b1; z_we = 1'b1; z_mode = LS_W; z_addr = 32'h4; z_wdata = 32'h11223344;
        @(posedge clk); #1;
        check("W0 sw valid", 32'(z_rvalid), 32'd1);
        check("W0 sw ready", 32'(z_ready), 32'd0);
        check("W0 sw rdata", z_rdata, 32'd0);
        check("W0 sw err", 32'(z_err), 32'd0);
        z_we = 1'b0; z_addr = 32'h4; z_mode = LS_W;
        @(posedge clk); #1;
        check("W0 gap valid", 32'(z_rvalid), 32'd0);
        check("W0 gap ready", 32'(z_ready), 32'd1);
        @(posedge clk); #1;
        check("W0 lw valid", 32'(z_rvalid), 32'd1);
        check("W0 lw rdata", z_rdata, 32'h11223344);
        z_mode = LS_HU; z_addr = 32'h6;
        @(posedge clk); #1;
        check("W0 gap2 valid", 32'(z_rvalid), 32'd0);
        @(posedge clk); #1;
        check("W0 lhu valid", 32'(z_rvalid), 32'd1);
        check("W0 lhu rdata", z_rdata, 32'h00001122);
        z_valid = 1'b0;
        @(posedge clk); #1;
        check("W0 end valid", 32'(z_rvalid), 32'd0);
        check("W0 end ready", 32'(z_ready), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 1024: number of 32-bit words in the storage array.
REQ-002 SHALL have parameter WAIT_CYCLES, default 1, range 0..15: wait states between request acceptance and response.
REQ-003 SHALL have port clk, input, 1 bit: single clock, rising edge.
REQ-004 SHALL have port reset, input, 1 bit: asynchronous reset, active-high.
REQ-005 SHALL have port i_req_valid, input, 1 bit: request present.
REQ-006 SHALL have port o_req_ready, output, 1 bit: responder can accept a request.
REQ-007 SHALL have port i_req_addr, input, 32 bits: byte address.
REQ-008 SHALL have port i_req_we, input, 1 bit: 1 = store, 0 = load.
REQ-009 SHALL have port i_req_mode, input, 3 bits: load_store_mode, RV32I funct3 encoding.
REQ-010 SHALL have port i_req_wdata, input, 32 bits: store data, LSB-aligned.
REQ-011 SHALL have port o_rsp_valid, output, 1 bit: response present.
REQ-012 SHALL have port i_rsp_ready, input, 1 bit: requester accepts the response.
REQ-013 SHALL have port o_rsp_rdata, output, 32 bits: load data, extended to 32 bits.
REQ-014 SHALL have port o_rsp_err, output, 1 bit: access fault.

Function
REQ-015 SHALL implement an FSM with states IDLE, WAIT and RESP.
REQ-016 SHALL drive o_req_ready=1 only in IDLE; a request is accepted on a clk edge where i_req_valid && o_req_ready.
REQ-017 SHALL register addr, we, mode and wdata at acceptance; request inputs are don't-care afterwards.
REQ-018 SHALL, on acceptance, go IDLE->WAIT with the wait counter loaded to WAIT_CYCLES-1; with WAIT_CYCLES=0 it SHALL go IDLE->RESP directly.
REQ-019 SHALL, in WAIT, decrement the counter each cycle and go to RESP on the edge where the counter is 0.
REQ-020 SHALL commit the store and capture the load data on the edge entering RESP; for WAIT_CYCLES=N, o_rsp_valid rises N+1 cycles after the accept edge.
REQ-021 SHALL hold o_rsp_valid, o_rsp_rdata and o_rsp_err stable in RESP until i_rsp_ready=1, then go RESP->IDLE; with no back-to-back acceptance, throughput is one request per N+2 cycles.
REQ-022 SHALL use these mode encodings:
  - 000 byte, sign-extended
  - 001 half, sign-extended
  - 010 word
  - 100 byte, zero-extended
  - 101 half, zero-extended
  - stores use the low two bits only: byte, half, word.
REQ-023 SHALL select the lane from addr[1:0]: byte lane = addr[1:0]; half lane = addr[1]; stores write only the addressed byte lanes, other lanes unchanged.
REQ-024 SHALL flag an error on any of: misaligned half (addr[0]=1), misaligned word (addr[1:0]!=0), addr[31:2] >= DEPTH_WORDS, or load mode 011, 110 or 111.
REQ-025 SHALL, on error, perform no write, return o_rsp_rdata=0 and o_rsp_err=1, with the same timing as a normal access.
REQ-026 SHALL return o_rsp_rdata=0 for stores.
REQ-027 SHALL deassert o_rsp_err outside RESP.

Reset
REQ-028 SHALL, on reset assertion, immediately force state IDLE, counter 0, o_rsp_valid=0, o_rsp_rdata=0 and o_rsp_err=0; o_req_ready=1 once reset is released.
REQ-029 SHALL, on reset mid-operation (WAIT or RESP), discard the pending request; a store not yet committed SHALL NOT be written.
REQ-030 SHALL NOT reset the storage array contents.

Structure
REQ-031 SHALL take the mode encodings (LS_B, LS_H, LS_W, LS_BU, LS_HU) and the FSM state enum from the shared package klp32_pkg.
REQ-032 SHALL contain one combinational sub-module, dmem_align, for byte-enable generation, store-data lane replication, load extraction and extension, and misalignment detection.
REQ-033 SHALL place the array in the top module as a word-wide array with per-byte write enables.

Verification
REQ-034 SHALL be verified, with WAIT_CYCLES=1: SW 0xDEADBEEF @0x10, then LW @0x10 -> rdata=0xDEADBEEF, err=0, o_rsp_valid high 2 cycles after each accept.
REQ-035 SHALL be verified by sub-word access: after the previous step, SB 0x7F @0x11, then LB @0x11 -> 0x0000007F; LBU @0x13 -> 0x000000DE; LH @0x12 -> 0xFFFFDEAD; LW @0x10 -> 0xDEAD7FEF.
REQ-036 SHALL be verified by faults: LW @0x12, SH @0x01 and LW @(DEPTH_WORDS*4) -> err=1, rdata=0; a subsequent LW @0x00 shows the word unchanged.
REQ-037 SHALL be verified by backpressure: hold i_rsp_ready=0 for 5 cycles in RESP -> o_rsp_valid/rdata stable and o_req_ready=0 throughout; accept completes on the first cycle with i_rsp_ready=1.
REQ-038 SHALL be verified by reset in WAIT during SW 0x12345678 @0x20 -> o_rsp_valid stays 0, o_req_ready=1 after release, LW @0x20 returns the prior contents.
REQ-039 SHALL be verified with WAIT_CYCLES=0: back-to-back requests with i_rsp_ready held at 1 -> response 1 cycle after each accept, one request per 2 cycles.
